fetch_entry_fifo: RTL

Instruction queue on the transmitting side of the IF→ID fetch-entry handshake. Buffers fetched instructions, with their PC and any fetch exception, from the frontend, and presents them one per cycle to id_stage through the `fetch_entry` valid/ready interface. Sits between the frontend realigner and id_stage. Decouples frontend stalls from decode back-pressure and supports a single-cycle flush on redirect.

---
 rtl/fetch_entry_fifo.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_entry_fifo.sv
// Fetch-entry queue between frontend and id_stage; FETCH_FIFO_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle push-to-valid (0 with bypass on an empty queue); 1 entry/cycle each way.
// Backpressure: instr_ready_o drops when full (registered count only); head held while ready_i low.
module fetch_entry_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64,
  parameter int unsigned XLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       instr_valid_i,
  input  logic [VLEN-1:0]            instr_addr_i,
  input  logic [31:0]                instr_i,
  input  logic                       ex_valid_i,
  input  logic [XLEN-1:0]            ex_cause_i,
  output logic                       instr_ready_o,
  output logic                       fetch_entry_valid_o,
  output logic [VLEN-1:0]            fetch_entry_addr_o,
  output logic [31:0]                fetch_entry_instr_o,
  output logic                       fetch_entry_ex_valid_o,
  output logic [XLEN-1:0]            fetch_entry_ex_cause_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
    logic            ex_valid;
    logic [XLEN-1:0] ex_cause;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            push;
  logic            store;
  logic            deq;

  assign in_entry = '{addr: instr_addr_i, instr: instr_i, ex_valid: ex_valid_i, ex_cause: ex_cause_i};

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready looks only at registered state, so a full queue refuses even when a pop coincides.
  assign instr_ready_o = !full && !rst_i;
  assign push          = instr_valid_i && instr_ready_o && !flush_i;

`ifdef FETCH_FIFO_BYPASS_EN
  logic bypass;

  assign bypass              = empty && push;
  assign fetch_entry_valid_o = (!empty || bypass) && !flush_i;
  assign head                = bypass ? in_entry : mem[rd_ptr];
  assign deq                 = fetch_entry_valid_o && fetch_entry_ready_i && !empty;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign store               = push && !(bypass && fetch_entry_ready_i);
`else
  assign fetch_entry_valid_o = !empty && !flush_i;
  assign head                = mem[rd_ptr];
  assign deq                 = fetch_entry_valid_o && fetch_entry_ready_i;
  assign store               = push;
`endif

  assign fetch_entry_addr_o     = head.addr;
  assign fetch_entry_instr_o    = head.instr;
  assign fetch_entry_ex_valid_o = head.ex_valid;
  assign fetch_entry_ex_cause_o = head.ex_cause;
  assign count_o                = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({store, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
